// File: rtl/wired_pc_fifo.sv
// Fetch-packet decoupling queue between the PC generator/predictor and the
// instruction-cache request stage. Holds fetch groups in order. A backend
// redirect drops everything buffered.
module wired_pc_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PRED_W = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  p_valid_i,
  output logic                  p_ready_o,
  input  logic [31:0]           p_pc_i,
  input  logic [1:0]            p_mask_i,
  input  logic [2*PRED_W-1:0]   p_predict_i,
  output logic                  f_valid_o,
  input  logic                  f_ready_i,
  output logic [31:0]           f_pc_o,
  output logic [1:0]            f_mask_o,
  output logic [2*PRED_W-1:0]   f_predict_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned PCW  = 29;
  localparam int unsigned PDW  = 2 * PRED_W;
  localparam int unsigned EW   = PCW + 2 + PDW;

  // Reject configurations the pointer wrap arithmetic cannot handle.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("wired_pc_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic [CW-1:0] cnt;
  logic [EW-1:0] head;

  logic push;
  logic wr;
  logic pop;

  // The low PC bits are implied by the 8-byte fetch-group alignment.
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^p_pc_i[2:0];

  // Ready and valid come from the registered count only; no path from f_ready_i.
  assign p_ready_o = (cnt != CW'(DEPTH));
  assign f_valid_o = (cnt != CW'(0));
  assign count_o   = cnt;

  // Handshakes; a zero-mask packet is accepted but never stored.
  assign push = p_valid_i && p_ready_o && !flush_i;
  assign wr   = push && (p_mask_i != 2'b00);
  assign pop  = f_valid_o && f_ready_i && !flush_i;

  // Head entry presentation.
  assign head        = mem[rptr];
  assign f_pc_o      = {head[EW-1 -: PCW], 3'b000};
  assign f_mask_o    = head[PDW +: 2];
  assign f_predict_o = head[PDW-1:0];

  // Entry storage; left unreset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (wr && !rst) begin
      mem[wptr] <= {p_pc_i[31:3], p_mask_i, p_predict_i};
    end
  end

  // Pointers and occupancy; reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else if (flush_i) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({wr, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Structural invariants of the queue state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (cnt <= CW'(DEPTH))
        else $error("wired_pc_fifo: occupancy above DEPTH");
      assert (!(wr && (cnt == CW'(DEPTH))))
        else $error("wired_pc_fifo: write while full");
      assert ((wptr - rptr) == cnt[AW-1:0])
        else $error("wired_pc_fifo: pointer distance disagrees with occupancy");
    end
  end

endmodule

// File: tb/tb_wired_pc_fifo.sv
// Scoreboard bench for wired_pc_fifo: directed test-plan scenarios followed by
// randomized traffic with flushes and resets.
module tb_wired_pc_fifo;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PRED_W = 48;
  localparam int unsigned PDW    = 2 * PRED_W;

  typedef struct {
    logic [31:0]    pc;
    logic [1:0]     mask;
    logic [PDW-1:0] pred;
  } pkt_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   flush_i;
  logic                   p_valid_i;
  logic                   p_ready_o;
  logic [31:0]            p_pc_i;
  logic [1:0]             p_mask_i;
  logic [PDW-1:0]         p_predict_i;
  logic                   f_valid_o;
  logic                   f_ready_i;
  logic [31:0]            f_pc_o;
  logic [1:0]             f_mask_o;
  logic [PDW-1:0]         f_predict_o;
  logic [$clog2(DEPTH):0] count_o;

  int errors = 0;
  int checks = 0;
  int model_cnt = 0;
  pkt_t exp_q[$];

  wired_pc_fifo #(.DEPTH(DEPTH), .PRED_W(PRED_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .p_valid_i   (p_valid_i),
    .p_ready_o   (p_ready_o),
    .p_pc_i      (p_pc_i),
    .p_mask_i    (p_mask_i),
    .p_predict_i (p_predict_i),
    .f_valid_o   (f_valid_o),
    .f_ready_i   (f_ready_i),
    .f_pc_o      (f_pc_o),
    .f_mask_o    (f_mask_o),
    .f_predict_o (f_predict_o),
    .count_o     (count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [PDW-1:0] act, input logic [PDW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PDW-1:0] rand_pred();
    logic [PDW-1:0] r;
    r = {$urandom, $urandom, $urandom};
    return r;
  endfunction

  // Monitor: compares the presented head with the oldest expected packet and
  // retires it when the cache stage takes it.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (f_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_head_valid", PDW'(1), PDW'(0));
        end else begin
          chk("head_pc", PDW'(f_pc_o), PDW'(exp_q[0].pc));
          chk("head_mask", PDW'(f_mask_o), PDW'(exp_q[0].mask));
          chk("head_predict", f_predict_o, exp_q[0].pred);
        end
      end
      if (flush_i) begin
        exp_q.delete();
      end else if (f_valid_o && f_ready_i && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
      end
    end
  end

  // One cycle: check occupancy-derived outputs against the model, then offer
  // the given inputs for the next clock edge and record what should be queued.
  task automatic step(input logic v, input logic [31:0] pc, input logic [1:0] m,
                      input logic r, input logic fl, input logic rs);
    pkt_t p;
    logic [PDW-1:0] pr;
    chk("count", PDW'(count_o), PDW'(model_cnt));
    chk("p_ready", PDW'(p_ready_o), PDW'(model_cnt != DEPTH));
    chk("f_valid", PDW'(f_valid_o), PDW'(model_cnt != 0));
    pr = rand_pred();
    p_valid_i   = v;
    p_pc_i      = pc;
    p_mask_i    = m;
    p_predict_i = pr;
    f_ready_i   = r;
    flush_i     = fl;
    rst         = rs;
    if (rs || fl) begin
      model_cnt = 0;
    end else begin
      if (r && model_cnt != 0) model_cnt--;
      if (v && (model_cnt + ((r && model_cnt != 0) ? 1 : 0)) != DEPTH && m != 2'b00) begin
        p.pc   = {pc[31:3], 3'b000};
        p.mask = m;
        p.pred = pr;
        exp_q.push_back(p);
        model_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic r);
    step(1'b0, 32'h0, 2'b00, r, 1'b0, 1'b0);
  endtask

  initial begin
    int pre;
    rst = 1'b1; flush_i = 1'b0; p_valid_i = 1'b0; f_ready_i = 1'b0;
    p_pc_i = '0; p_mask_i = '0; p_predict_i = '0;
    @(posedge clk); #1;
    step(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;

    // Single push, head holds while stalled, then drains.
    step(1'b1, 32'h1c000000, 2'b11, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    // Fill to full, overflow attempt, then drain in order.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h1000 + 32'(i * 8), 2'b11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h1020, 2'b01, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h1028, 2'b01, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Streaming at one packet per cycle across pointer wrap.
    for (int i = 0; i < 20; i++) step(1'b1, 32'h4000 + 32'(i * 8), 2'b11, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Zero-mask filtering and PC low-bit clearing.
    step(1'b1, 32'h2004, 2'b10, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h2008, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h2010, 2'b01, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Flush with three queued, offered push and ready all together.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h3000 + 32'(i * 8), 2'b11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h3100, 2'b11, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h3200, 2'b10, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);
    step(1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0);

    // Reset mid-stream with push and pop both offered.
    step(1'b1, 32'h5000, 2'b11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h5008, 2'b11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h5010, 2'b11, 1'b1, 1'b0, 1'b1);
    idle(1'b0);
    step(1'b1, 32'h5100, 2'b01, 1'b0, 1'b0, 1'b0);
    idle(1'b1);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(99) < 70) ? 1'b1 : 1'b0,
           $urandom,
           2'($urandom_range(3)),
           ($urandom_range(99) < 55) ? 1'b1 : 1'b0,
           ($urandom_range(99) < 3) ? 1'b1 : 1'b0,
           ($urandom_range(99) < 1) ? 1'b1 : 1'b0);
    end

    pre = model_cnt;
    for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);
    chk("drained_queue_size", PDW'(exp_q.size()), PDW'(0));
    if (pre < 0) $display("unreachable");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wired_pc_fifo.md
Name: wired_pc_fifo

Overview:
- Decoupling queue directly downstream of the PC generator / branch predictor.
- Each cycle it accepts one fetch packet from the predictor: an 8-byte-aligned fetch-group PC, a 2-bit slot mask, and per-slot prediction metadata.
- It buffers packets in order and presents them to the instruction-cache request stage with a valid/ready handshake.
- A backend redirect flushes all buffered packets so stale-path fetches never reach the cache.

Parameters:
- DEPTH, 4, number of packet entries; must be a power of two, minimum 2.
- PRED_W, 48, width in bits of one slot's prediction record; the predict port carries 2*PRED_W bits, with slot 0 in the low half.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush_i  in  1  redirect/flush; discards all queued packets this cycle.
- p_valid_i  in  1  predictor packet valid.
- p_ready_o  out  1  queue can accept a packet.
- p_pc_i  in  32  fetch-group PC; bits [2:0] are ignored and stored as 0.
- p_mask_i  in  2  slot valid mask; bit0 = pc+0, bit1 = pc+4.
- p_predict_i  in  2*PRED_W  per-slot prediction records.
- f_valid_o  out  1  head packet valid.
- f_ready_i  in  1  cache stage accepts the head.
- f_pc_o  out  32  head PC.
- f_mask_o  out  2  head mask.
- f_predict_o  out  2*PRED_W  head prediction records.
- count_o  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage:
  - Circular buffer of DEPTH entries, each {pc[31:3], mask, predict}.
  - Read pointer rptr and write pointer wptr, each $clog2(DEPTH) bits, wrapping naturally at DEPTH-1 -> 0.
  - Occupancy counter cnt, 0..DEPTH.
- Handshakes:
  - push = p_valid_i && p_ready_o && !flush_i.
  - pop = f_valid_o && f_ready_i && !flush_i.
- Filtering: a push with p_mask_i == 2'b00 completes the handshake but writes nothing; pointers and cnt are unchanged.
- p_ready_o = (cnt != DEPTH):
  - Derived from registered state only, with no combinational path from f_ready_i.
  - When the queue is full, a pop in the same cycle does not free space for a push that cycle.
- Outputs:
  - f_valid_o = (cnt != 0).
  - f_pc_o / f_mask_o / f_predict_o are the entry at rptr, with f_pc_o[2:0] = 0.
  - There is no input-to-output bypass. Minimum latency is 1 cycle: a push in cycle N is visible on f_* in cycle N+1.
  - Output fields are don't-care while f_valid_o = 0.
  - The head is held stable while f_valid_o && !f_ready_i.
- Updates per cycle:
  - push only: write at wptr, wptr+1, cnt+1.
  - pop only: rptr+1, cnt-1.
  - push and pop: both pointers advance, cnt unchanged. Legal at any cnt in 1..DEPTH-1, and at cnt = 0 is impossible since f_valid_o = 0.
- Flush:
  - On flush_i = 1: rptr <= 0, wptr <= 0, cnt <= 0.
  - Any push or pop offered that cycle is ignored. The predictor's offered packet is lost by design, since the predictor drops valid during redirect anyway.
  - The next cycle shows f_valid_o = 0 and p_ready_o = 1.
  - Flush while empty is harmless.
- Reset:
  - rst = 1 at the clock edge gives rptr = wptr = 0 and cnt = 0.
  - Outputs after reset: f_valid_o = 0, p_ready_o = 1, count_o = 0.
  - Reset takes precedence over flush, push and pop, including when asserted mid-stream.
  - Entry storage is not reset; distributed RAM is allowed.
- count_o = cnt, registered.
- Assertions for verification:
  - cnt never exceeds DEPTH.
  - No push while p_ready_o = 0.
  - (wptr - rptr) mod DEPTH == cnt mod DEPTH.

Test Plan:
- Reset, then push pc = 0x1c000000 with mask 2'b11 in cycle 1 while f_ready_i = 0 -> in cycle 2, f_valid_o = 1, f_pc_o = 0x1c000000, f_mask_o = 2'b11, count_o = 1; the head holds until f_ready_i = 1.
- Fill at DEPTH = 4 with pcs 0x1000, 0x1008, 0x1010, 0x1018 while f_ready_i = 0 -> p_ready_o = 0 after the 4th push. Raise f_ready_i -> pops in order 0x1000..0x1018, and p_ready_o returns to 1 the cycle after the first pop.
- Streaming with both valids held high for 20 cycles and pcs incrementing by 8 -> throughput of 1 packet/cycle, count_o steady at 1, no loss or reordering across pointer wrap.
- Push p_pc_i = 0x2004 with mask 2'b10, then 0x2008 with mask 2'b00, then 0x2010 with mask 2'b01 -> output sequence is {0x2000, 2'b10} then {0x2010, 2'b01}; the zero-mask packet never appears.
- With 3 entries queued, assert flush_i together with p_valid_i and f_ready_i -> next cycle f_valid_o = 0, count_o = 0; the offered packet is not stored and no pop is counted. A push one cycle later reappears at the head one cycle after that.
- Assert rst with 2 entries queued and push/pop both active -> next cycle count_o = 0, f_valid_o = 0, p_ready_o = 1.
